// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave arbiter for the picorv32 native memory bus.
// Optional round-robin tie-break: define MEM_BUS_ARB_ROUND_ROBIN_EN.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  gnt,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY0 = 2'b01,
        BUSY1 = 2'b10
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        own_valid;
    logic [31:0] own_addr;
    logic [31:0] own_wdata;
    logic [3:0]  own_wstrb;
    logic        busy;
    logic        tmo;
    logic        rdy;
    logic [31:0] rd;
    logic        any_req;
    logic        pick1;

    assign busy    = (state_q != IDLE);
    assign any_req = m0_valid | m1_valid;

`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
    // ptr_q = 1 means m1 held the last grant, so m0 wins the next tie
    logic ptr_q;

    assign pick1 = m1_valid & (~m0_valid | ~ptr_q);

    // Last-grant pointer, updated whenever IDLE hands out a grant
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= 1'b1;
        end else if (state_q == IDLE && any_req) begin
            ptr_q <= pick1;
        end
    end
`else
    assign pick1 = m1_valid & ~m0_valid;
`endif

    // Select the owning master's request fields; all zero while idle
    always_comb begin
        own_valid = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        own_wstrb = '0;
        unique case (1'b1)
            state_q == BUSY0: begin
                own_valid = m0_valid;
                own_addr  = m0_addr;
                own_wdata = m0_wdata;
                own_wstrb = m0_wstrb;
            end
            state_q == BUSY1: begin
                own_valid = m1_valid;
                own_addr  = m1_addr;
                own_wdata = m1_wdata;
                own_wstrb = m1_wstrb;
            end
            default: ;
        endcase
    end

    // Watchdog completion: a real s_ready always takes precedence
    assign tmo = busy & own_valid & ~s_ready & (cnt_q == TMO_LAST);

    assign s_valid     = own_valid & ~tmo;
    assign s_addr      = own_addr;
    assign s_wdata     = own_wdata;
    assign s_wstrb     = tmo ? 4'b0000 : own_wstrb;
    assign err_timeout = tmo;

    assign rdy = s_ready | tmo;
    assign rd  = tmo ? ERR_RDATA : s_rdata;

    assign m0_ready = (state_q == BUSY0) & rdy;
    assign m0_rdata = (state_q == BUSY0) ? rd : 32'h0;
    assign m1_ready = (state_q == BUSY1) & rdy;
    assign m1_rdata = (state_q == BUSY1) ? rd : 32'h0;

    assign gnt = state_q;

    // Arbitration FSM with per-transfer watchdog counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q <= 8'd0;
                    if (any_req) begin
                        state_q <= pick1 ? BUSY1 : BUSY0;
                    end
                end
                default: begin
                    if (!own_valid || (s_ready && s_valid) || tmo) begin
                        state_q <= IDLE;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: slave model, per-master expect queues,
// grant-order log.
module tb_mem_bus_arbiter;

    localparam logic [31:0] K = 32'hC0DE_0000;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  gnt;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   glog[$];
    int   gaplog[$];

    int          sl_lat = 0;
    int          sl_cnt = 0;
    bit          sl_fix_en = 0;
    logic [31:0] sl_fix = '0;
    logic [1:0]  prev_gnt = 2'b00;
    int          idle_cnt = 0;

    mem_bus_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0_valid    (m0_valid),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_wstrb    (m0_wstrb),
        .m0_ready    (m0_ready),
        .m0_rdata    (m0_rdata),
        .m1_valid    (m1_valid),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_wstrb    (m1_wstrb),
        .m1_ready    (m1_ready),
        .m1_rdata    (m1_rdata),
        .s_valid     (s_valid),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .gnt         (gnt),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model (ready after sl_lat+1 busy cycles, -1 = never) and monitor
    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            sl_cnt  = 0;
            s_ready = 1'b0;
        end else begin
            if (gnt != 2'b00) sl_cnt++;
            else sl_cnt = 0;
            s_ready = (sl_lat >= 0) && (sl_cnt == sl_lat + 1);
        end
        s_rdata = sl_fix_en ? sl_fix : (s_addr ^ K);
        #1;
        if (m0_ready) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL sb_m0 unexpected ready got 1 want 0");
            end else begin
                e = q0.pop_front();
                if (m0_rdata !== e.rdata || err_timeout !== e.err) begin
                    errors++;
                    $display("FAIL sb_m0 rdata/err got %h/%b want %h/%b",
                             m0_rdata, err_timeout, e.rdata, e.err);
                end
            end
        end
        if (m1_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL sb_m1 unexpected ready got 1 want 0");
            end else begin
                e = q1.pop_front();
                if (m1_rdata !== e.rdata || err_timeout !== e.err) begin
                    errors++;
                    $display("FAIL sb_m1 rdata/err got %h/%b want %h/%b",
                             m1_rdata, err_timeout, e.rdata, e.err);
                end
            end
        end
        if (gnt != 2'b00 && prev_gnt == 2'b00) begin
            glog.push_back((gnt == 2'b10) ? 1 : 0);
            gaplog.push_back(idle_cnt);
        end
        if (gnt == 2'b00) idle_cnt++;
        else idle_cnt = 0;
        prev_gnt = gnt;
    end

    task automatic m_xfer(input int m, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws);
        exp_t e;
        bit   seen;
        e.rdata = a ^ K;
        e.err   = 1'b0;
        if (m == 0) begin
            q0.push_back(e);
            m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_valid = 1'b1;
        end else begin
            q1.push_back(e);
            m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_valid = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk); #2;
            seen = (m == 0) ? m0_ready : m1_ready;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL xfer_wait m%0d ready got 0 want 1", m);
        end
        @(posedge clk); #1;
        if (m == 0) m0_valid = 1'b0;
        else m1_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (gnt !== 2'b00 || s_valid !== 1'b0 || s_wstrb !== 4'b0 ||
            m0_ready !== 1'b0 || m1_ready !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b sv=%b ws=%b r0=%b r1=%b e=%b want all 0",
                     gnt, s_valid, s_wstrb, m0_ready, m1_ready, err_timeout);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_m0_read();
        exp_t e;
        sl_fix_en = 1; sl_fix = 32'h1234_5678; sl_lat = 1;
        e.rdata = 32'h1234_5678; e.err = 1'b0;
        q0.push_back(e);
        m0_addr = 32'h10; m0_wdata = 0; m0_wstrb = 0; m0_valid = 1'b1;
        @(negedge clk); #2;
        checks++;
        if (gnt !== 2'b00 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_arb_cycle gnt/sv got %b/%b want 00/0", gnt, s_valid);
        end
        @(negedge clk); #2;
        checks++;
        if (gnt !== 2'b01 || s_valid !== 1'b1 || s_addr !== 32'h10 || m0_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd_busy gnt=%b sv=%b a=%h r0=%b want 01 1 10 0",
                     gnt, s_valid, s_addr, m0_ready);
        end
        @(negedge clk); #2;
        checks++;
        if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd_done r0/r1 got %b/%b want 1/0", m0_ready, m1_ready);
        end
        @(posedge clk); #1;
        m0_valid = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (gnt !== 2'b00 || m0_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd_idle gnt/r0 got %b/%b want 00/0", gnt, m0_ready);
        end
        sl_fix_en = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_m1_write();
        exp_t e;
        sl_lat = 0;
        e.rdata = 32'h20 ^ K; e.err = 1'b0;
        q1.push_back(e);
        m1_addr = 32'h20; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0011;
        m1_valid = 1'b1;
        @(negedge clk); #2;
        @(negedge clk); #2;
        checks++;
        if (gnt !== 2'b10 || s_valid !== 1'b1 || s_addr !== 32'h20 ||
            s_wdata !== 32'hA5A5_A5A5 || s_wstrb !== 4'b0011) begin
            errors++;
            $display("FAIL wr_fields gnt=%b sv=%b a=%h d=%h s=%b want 10 1 20 a5a5a5a5 0011",
                     gnt, s_valid, s_addr, s_wdata, s_wstrb);
        end
        checks++;
        if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_ready r1/r0 got %b/%b want 1/0", m1_ready, m0_ready);
        end
        @(posedge clk); #1;
        m1_valid = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (gnt !== 2'b00 || m1_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_idle gnt/r1 got %b/%b want 00/0", gnt, m1_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int exp_g[8];
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        sl_lat = 0;
        glog.delete();
        gaplog.delete();
        for (int i = 0; i < 8; i++) begin
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
            exp_g[i] = i % 2;
`else
            exp_g[i] = (i < 4) ? 0 : 1;
`endif
        end
        fork
            begin
                for (int i = 0; i < 4; i++)
                    m_xfer(0, 32'h100 + 32'(i * 4), 32'h0, 4'b0);
            end
            begin
                for (int i = 0; i < 4; i++)
                    m_xfer(1, 32'h200 + 32'(i * 4), 32'h0, 4'b0);
            end
        join
        @(negedge clk); #2;
        checks++;
        if (glog.size() != 8) begin
            errors++;
            $display("FAIL b2b_count grants got %0d want 8", glog.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (glog[i] != exp_g[i]) begin
                    errors++;
                    $display("FAIL b2b_order[%0d] owner got m%0d want m%0d",
                             i, glog[i], exp_g[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (gaplog[i] != 1) begin
                        errors++;
                        $display("FAIL b2b_gap[%0d] idle cycles got %0d want 1",
                                 i, gaplog[i]);
                    end
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   early;
        sl_lat = -1;
        e.rdata = 32'hDEAD_BEEF; e.err = 1'b1;
        q0.push_back(e);
        m0_addr = 32'h0020_0000; m0_wdata = 32'h1111_2222; m0_wstrb = 4'b1111;
        m0_valid = 1'b1;
        @(negedge clk); #2;
        early = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk); #2;
            if (k < 16) begin
                if (m0_ready !== 1'b0 || err_timeout !== 1'b0 || gnt !== 2'b01)
                    early = 1'b1;
            end
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL tmo_early ready/err before cycle 16 got 1 want 0");
        end
        checks++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || err_timeout !== 1'b1 ||
            s_wstrb !== 4'b0 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_cycle r=%b d=%h e=%b ws=%b sv=%b want 1 deadbeef 1 0000 0",
                     m0_ready, m0_rdata, err_timeout, s_wstrb, s_valid);
        end
        @(posedge clk); #1;
        m0_valid = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (gnt !== 2'b00 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_idle gnt/err got %b/%b want 00/0", gnt, err_timeout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ready_on_timeout();
        exp_t e;
        sl_lat = 15;
        e.rdata = 32'h40 ^ K; e.err = 1'b0;
        q0.push_back(e);
        m0_addr = 32'h40; m0_wdata = 0; m0_wstrb = 0; m0_valid = 1'b1;
        @(negedge clk); #2;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk); #2;
        end
        checks++;
        if (m0_ready !== 1'b1 || m0_rdata !== (32'h40 ^ K) || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL race_cycle r=%b d=%h e=%b want 1 %h 0",
                     m0_ready, m0_rdata, err_timeout, 32'h40 ^ K);
        end
        @(posedge clk); #1;
        m0_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_busy();
        sl_lat = -1;
        m1_addr = 32'h30; m1_wdata = 0; m1_wstrb = 0; m1_valid = 1'b1;
        @(negedge clk); #2;
        @(negedge clk); #2;
        @(negedge clk); #1;
        checks++;
        if (gnt !== 2'b10 || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre gnt/sv got %b/%b want 10/1", gnt, s_valid);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b00 || s_valid !== 1'b0 || m1_ready !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_async gnt=%b sv=%b r1=%b e=%b want 00 0 0 0",
                     gnt, s_valid, m1_ready, err_timeout);
        end
        @(posedge clk); #1;
        m1_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        sl_lat = 1;
        m_xfer(0, 32'h80, 32'h0, 4'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        resetn = 1'b0;
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_m0_read();
        test_m1_write();
        test_back_to_back();
        test_timeout();
        test_ready_on_timeout();
        test_reset_mid_busy();
        repeat (3) @(posedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending got %0d/%0d want 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1);
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the picorv32-style native memory bus (valid/ready, addr/wdata/wstrb/rdata).
- Shares the SoC memory decode (RAM + ROM) between the CPU (master 0) and a DMA/debug engine (master 1).
- Sits between picorv32 `mem_*` and the RAM/ROM ready/rdata mux.
- Includes a per-transaction watchdog so a transfer to an unmapped address cannot hang the bus.

Parameters:
- TIMEOUT, 16, max cycles in a BUSY state without s_ready before forced completion; legal 2..255.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out transfer.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; one clock; asynchronous, active-low
- m0_valid  in  1  master 0 request
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes (0 = read)
- m0_ready  out  1  master 0 completion
- m0_rdata  out  32  master 0 read data
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as master 0, for master 1
- s_valid  out  1  slave request
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_wstrb  out  4  slave strobes
- s_ready  in  1  slave completion
- s_rdata  in  32  slave read data
- gnt  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 0 when idle
- err_timeout  out  1  one-cycle pulse on watchdog completion

Behaviour:
- FSM states: IDLE, BUSY0, BUSY1. Registered state and grant.
- Reset (async, resetn low): state = IDLE, gnt = 0, err_timeout = 0, timeout counter = 0, RR pointer = 1. All m*_ready, s_valid and s_wstrb are 0 during reset.
- IDLE:
  - s_valid = 0; s_addr, s_wdata and s_wstrb are 0.
  - If any m*_valid, the next state is BUSYx per arbitration policy. One cycle of arbitration latency.
  - Transfers are never started combinationally from IDLE.
- BUSYx:
  - s_valid = mx_valid; s_addr, s_wdata and s_wstrb are combinationally muxed from master x.
  - mx_ready = s_ready and mx_rdata = s_rdata (combinational pass-through).
  - The non-owner's ready is 0 and its rdata is 0.
- Completion:
  - On a cycle with s_ready && s_valid, the next state is IDLE and the counter clears.
  - Between consecutive transfers there is always at least one IDLE cycle. This satisfies picorv32 valid-drop timing and the slave's `!mem_ready` qualification.
- Watchdog:
  - The counter increments each BUSY cycle without s_ready.
  - When the counter reaches TIMEOUT-1 without s_ready, the arbiter drives mx_ready = 1 and mx_rdata = ERR_RDATA for that cycle.
  - In that cycle s_valid is forced 0 and s_wstrb is forced 0, so no write lands.
  - err_timeout pulses 1 in that cycle; the next state is IDLE.
- Master abort: if the owner drops mx_valid while in BUSYx, the next state is IDLE and the counter clears; no ready is issued.
- Simultaneous s_ready and timeout in the same cycle: s_ready wins, a normal completion with s_rdata; no err_timeout.
- Request held across a grant: the non-granted master's valid stays pending and wins the next IDLE cycle if it is the only requester.
- Reset mid-transfer: immediate return to IDLE; an in-flight slave access is abandoned, and the slave must tolerate a valid drop.
- gnt equals the registered state encoding: IDLE = 2'b00, BUSY0 = 2'b01, BUSY1 = 2'b10.

Optional Feature:
- Macro: MEM_BUS_ARB_ROUND_ROBIN_EN.
- Defined: when both masters request in IDLE, grant goes to the master not granted last. A 1-bit last-grant pointer updates on each grant; its reset value is 1, so m0 wins the first tie.
- Undefined: fixed priority; m0 always wins a tie, and m1 can starve under continuous CPU traffic. The pointer register is not instantiated.

Test Plan:
- m0 reads 0x0000_0010 alone, slave ready 1 cycle after s_valid with s_rdata 0x1234_5678 -> gnt = 01 from cycle 1; m0_ready pulses once with m0_rdata = 0x1234_5678; m1_ready stays 0; FSM returns to IDLE.
- m1 writes 0x0000_0020 with wdata 0xA5A5_A5A5 and wstrb 4'b0011 -> s_addr, s_wdata and s_wstrb match exactly while gnt = 10; m1_ready pulses on s_ready.
- Both masters assert valid on the same cycle, repeated for 4 back-to-back transfers each -> fixed priority: grants are m0, m0, m0, m0, then m1. With MEM_BUS_ARB_ROUND_ROBIN_EN: grants are m0, m1, m0, m1, and so on, each separated by exactly 1 IDLE cycle.
- m0 accesses unmapped 0x0020_0000 (s_ready never asserted), TIMEOUT = 16 -> at the 16th BUSY cycle m0_ready = 1, m0_rdata = 0xDEAD_BEEF, err_timeout pulses 1, s_wstrb = 0 in that cycle; FSM returns to IDLE.
- s_ready asserted exactly on the timeout cycle -> normal completion with s_rdata; err_timeout stays 0.
- resetn pulled low asynchronously mid-BUSY1 -> gnt, s_valid, m1_ready and err_timeout all go 0 without waiting for a clock edge; after release, the first request is serviced normally.
